// File: rtl/vga_fetch.sv
// vga_fetch: 640x480@60 VGA timing plus RGB332 framebuffer fetch over a credit-limited word FIFO.
// Define VGA_FETCH_TEST_PATTERN_EN to replace the fetcher with an h^v pattern; V_* shrink the frame.
module vga_fetch #(
   parameter logic [1:0] ID      = 2'd3,
   parameter int         FIFO_LG = 6,
   parameter int         V_ACT   = 480,
   parameter int         V_SS    = 490,
   parameter int         V_SE    = 492,
   parameter int         V_TOT   = 525
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [29:0] fb_base,
   input  logic        mem_waitrequest,
   output logic [1:0]  mem_id,
   output logic [29:0] mem_address,
   output logic        mem_read,
   input  logic [31:0] mem_readdata,
   input  logic [1:0]  mem_readdataid,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        underflow
);
   localparam logic [9:0] LV_ACT = 10'(V_ACT);
   localparam logic [9:0] LV_SS  = 10'(V_SS);
   localparam logic [9:0] LV_SE  = 10'(V_SE);
   localparam logic [9:0] LV_END = 10'(V_TOT - 1);

   logic [9:0] r_h, r_v;
   logic       w_act, w_blk;
   logic [7:0] w_p;

   assign mem_id = ID;
   assign w_act  = (r_h < 10'd640) && (r_v < LV_ACT);

   always_ff @(posedge clk)
      if (!reset_n) begin
         r_h <= '0;
         r_v <= '0;
      end else begin
         r_h <= (r_h == 10'd799) ? 10'd0 : r_h + 10'd1;
         if (r_h == 10'd799) r_v <= (r_v == LV_END) ? 10'd0 : r_v + 10'd1;
      end

`ifdef VGA_FETCH_TEST_PATTERN_EN
   logic w_unused;
   assign w_unused    = ^{enable, fb_base, mem_waitrequest, mem_readdata, mem_readdataid};
   assign mem_read    = 1'b0;
   assign mem_address = '0;
   assign underflow   = 1'b0;
   assign w_p         = r_h[7:0] ^ r_v[7:0];
   assign w_blk       = 1'b0;
`else
   localparam logic [16:0] LNW = 17'(V_ACT * 160);

   logic               r_en, r_pend, r_uf, r_blk;
   logic [29:0]        r_addr;
   logic [16:0]        r_iss;
   logic [FIFO_LG:0]   r_out, r_cnt;
   logic [FIFO_LG-1:0] r_wp, r_rp;
   logic [31:0]        r_mem [2**FIFO_LG];
   logic [31:0]        r_word;
   logic [31:0]        w_head, w_src;
   logic               w_trig, w_credit, w_acc, w_ret, w_go, w_ph0, w_pop;

   assign w_trig      = (r_h == 10'd0) && (r_v == LV_SS);
   assign w_credit    = ({1'b0, r_cnt} + {1'b0, r_out}) < {2'b01, {FIFO_LG{1'b0}}};
   assign mem_read    = r_en && (r_iss < LNW) && w_credit;
   assign mem_address = r_addr;
   assign underflow   = r_uf;
   assign w_acc       = mem_read && !mem_waitrequest;
   // returns with nothing outstanding (stale after reset) are dropped
   assign w_ret       = (mem_readdataid == ID) && (r_out != '0);
   assign w_go        = (w_trig || r_pend) && (r_out == '0) && !w_acc;
   assign w_ph0       = w_act && (r_h[1:0] == 2'd0);
   assign w_pop       = w_ph0 && r_en && (r_cnt != '0);
   assign w_head      = r_mem[r_rp];
   assign w_src       = (r_h[1:0] == 2'd0) ? w_head : r_word;
   assign w_p         = w_src[{~r_h[1:0], 3'b000} +: 8];
   assign w_blk       = (r_h[1:0] == 2'd0) ? !w_pop : r_blk;

   always_ff @(posedge clk)
      if (w_ret) r_mem[r_wp] <= mem_readdata;

   always_ff @(posedge clk)
      if (!reset_n) begin
         r_en   <= 1'b0;
         r_pend <= 1'b0;
         r_uf   <= 1'b0;
         r_blk  <= 1'b1;
         r_addr <= '0;
         r_iss  <= '0;
         r_out  <= '0;
         r_cnt  <= '0;
         r_wp   <= '0;
         r_rp   <= '0;
         r_word <= '0;
      end else begin
         r_pend <= (w_trig || r_pend) && !w_go;
         r_out  <= r_out + {{FIFO_LG{1'b0}}, w_acc} - {{FIFO_LG{1'b0}}, w_ret};
         if (w_ph0 && r_en && (r_cnt == '0)) r_uf <= 1'b1;
         if (w_ph0) r_blk <= !w_pop;
         if (w_pop) r_word <= w_head;
         if (w_go) begin
            r_en   <= enable;
            r_addr <= fb_base;
            r_iss  <= '0;
            r_cnt  <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
         end else begin
            if (w_acc) r_addr <= r_addr + 30'd1;
            if (w_acc) r_iss <= r_iss + 17'd1;
            if (w_ret) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + {{FIFO_LG{1'b0}}, w_ret} - {{FIFO_LG{1'b0}}, w_pop};
         end
      end
`endif

   always_ff @(posedge clk)
      if (!reset_n) begin
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
      end else begin
         vga_r       <= (w_act && !w_blk) ? {w_p[7:5], w_p[7:5], w_p[7:6]} : 8'd0;
         vga_g       <= (w_act && !w_blk) ? {w_p[4:2], w_p[4:2], w_p[4:3]} : 8'd0;
         vga_b       <= (w_act && !w_blk) ? {4{w_p[1:0]}} : 8'd0;
         vga_hs      <= !((r_h >= 10'd656) && (r_h <= 10'd751));
         vga_vs      <= !((r_v >= LV_SS) && (r_v < LV_SE));
         vga_blank_n <= w_act;
      end
endmodule

// File: tb/tb_vga_fetch.sv
// tb_vga_fetch: directed bench for vga_fetch on a shortened 8-line frame with a 2-cycle-latency responder.
module tb_vga_fetch;
   localparam logic [1:0]  ID   = 2'd3;
   localparam logic [29:0] BASE = 30'h1000_0000;

   logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b1, mem_waitrequest = 1'b0;
   logic [29:0] fb_base = BASE;
   logic [1:0]  mem_id;
   logic [1:0]  mem_readdataid = 2'd0;
   logic [29:0] mem_address;
   logic        mem_read;
   logic [31:0] mem_readdata = 32'd0;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_blank_n, underflow;
   int          n_chk = 0, n_err = 0, t = 0;

   always #20 clk = ~clk;

   vga_fetch #(.ID(ID), .FIFO_LG(6), .V_ACT(4), .V_SS(6), .V_SE(7), .V_TOT(8)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .fb_base(fb_base),
      .mem_waitrequest(mem_waitrequest), .mem_id(mem_id), .mem_address(mem_address),
      .mem_read(mem_read), .mem_readdata(mem_readdata), .mem_readdataid(mem_readdataid),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .vga_blank_n(vga_blank_n), .underflow(underflow));

   function automatic logic [31:0] word(input logic [29:0] a);
      logic [29:0] o;
      o = a - BASE;
      return (o == 30'd0) ? 32'hE01C_03FF : {o[7:0], o[7:0] ^ 8'h5A, 8'h3C, o[15:8]};
   endfunction

   logic        acc1 = 1'b0;
   logic [29:0] a1 = '0;
   always @(posedge clk) begin
      acc1           <= mem_read && !mem_waitrequest;
      a1             <= mem_address;
      mem_readdataid <= acc1 ? ID : 2'd0;
      mem_readdata   <= word(a1);
   end

   always @(posedge clk) t <= reset_n ? t + 1 : 0;

   int          n_acc = 0, n_early = 0, n_late = 0, n_seq = 0, n_ovf = 0, outs = 0;
   int          n_hs = 0, n_vs = 0, n_bl = 0;
   logic [29:0] a_first = '0, a_last = '0;
   always @(posedge clk)
      if (reset_n) begin
         if (mem_read && t < 4800) n_early <= n_early + 1;
         if (mem_read && t >= 17700) n_late <= n_late + 1;
         outs <= outs + ((mem_read && !mem_waitrequest) ? 1 : 0) - ((mem_readdataid == ID && outs > 0) ? 1 : 0);
         if (outs > 64) n_ovf <= n_ovf + 1;
         if (mem_read && !mem_waitrequest && t >= 4700 && t < 11100) begin
            if (n_acc == 0) a_first <= mem_address;
            else if (mem_address != a_last + 30'd1) n_seq <= n_seq + 1;
            a_last <= mem_address;
            n_acc  <= n_acc + 1;
         end
      end

   always @(negedge clk)
      if (t >= 6401 && t <= 12800) begin
         n_hs <= n_hs + (vga_hs ? 0 : 1);
         n_vs <= n_vs + (vga_vs ? 0 : 1);
         n_bl <= n_bl + (vga_blank_n ? 1 : 0);
      end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic at(input int k);
      while (t < k) @(negedge clk);
   endtask

   task automatic pix(input string tag, input int k, input logic [23:0] exp);
      at(k);
      check(tag, 32'({vga_r, vga_g, vga_b}), 32'(exp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
      check("rst_sync", 32'({vga_hs, vga_vs, vga_blank_n}), 32'b110);
      check("rst_read", 32'(mem_read), 32'd0);
      check("rst_addr", 32'(mem_address), 32'd0);
      check("rst_id", 32'(mem_id), 32'(ID));
      check("rst_uf", 32'(underflow), 32'd0);
      reset_n = 1'b1;
      at(640);  check("blank_639", 32'(vga_blank_n), 32'd1);
      at(641);  check("blank_640", 32'(vga_blank_n), 32'd0);
      at(656);  check("hs_655", 32'(vga_hs), 32'd1);
      at(657);  check("hs_656", 32'(vga_hs), 32'd0);
      at(752);  check("hs_751", 32'(vga_hs), 32'd0);
      at(753);  check("hs_752", 32'(vga_hs), 32'd1);
`ifdef VGA_FETCH_TEST_PATTERN_EN
      pix("tp_5_3", 2406, 24'h0024AA);
`endif
      at(4800); check("vs_before", 32'(vga_vs), 32'd1);
      at(4801); check("vs_low", 32'(vga_vs), 32'd0);
      check("no_early_read", 32'(n_early), 32'd0);
      at(5601); check("vs_after", 32'(vga_vs), 32'd1);
`ifdef VGA_FETCH_TEST_PATTERN_EN
      at(6400); check("tp_read", 32'(mem_read), 32'd0);
      check("tp_uf", 32'(underflow), 32'd0);
`else
      pix("px0", 6401, 24'hFF0000);
      pix("px1", 6402, 24'h00FF00);
      pix("px2", 6403, 24'h0000FF);
      pix("px3", 6404, 24'hFFFFFF);
      pix("px4", 6405, 24'h000055);
      pix("px5", 6406, 24'h49DBFF);
      pix("px_last", 9440, 24'h0000AA);
      at(11000); mem_waitrequest = 1'b1;
      at(11150);
      check("n_acc", 32'(n_acc), 32'd640);
      check("a_first", 32'(a_first), 32'(BASE));
      check("a_last", 32'(a_last), 32'(BASE + 30'd639));
      check("a_seq", 32'(n_seq), 32'd0);
      check("uf_clean", 32'(underflow), 32'd0);
      at(12000); check("stall_read", 32'(mem_read), 32'd1);
      check("stall_addr0", 32'(mem_address), 32'(BASE));
      at(12500); check("stall_addr1", 32'(mem_address), 32'(BASE));
      at(12800); check("uf_pre", 32'(underflow), 32'd0);
      at(12801); check("uf_rise", 32'(underflow), 32'd1);
      check("uf_black", 32'({vga_r, vga_g, vga_b}), 32'd0);
      check("uf_blank", 32'(vga_blank_n), 32'd1);
      check("f_hs_low", 32'(n_hs), 32'd768);
      check("f_vs_low", 32'(n_vs), 32'd800);
      check("f_blank_hi", 32'(n_bl), 32'd2560);
      at(13457); check("stall_hs", 32'(vga_hs), 32'd0);
      at(13600); mem_waitrequest = 1'b0; enable = 1'b0;
      pix("dis_black", 19201, 24'h000000);
      check("dis_blank", 32'(vga_blank_n), 32'd1);
      at(20000);
      check("dis_read", 32'(n_late), 32'd0);
      check("credit", 32'(n_ovf), 32'd0);
      check("uf_sticky", 32'(underflow), 32'd1);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/vga_fetch.md
# vga_fetch

Display-refresh initiator on the shared `mem_*` bus. It generates 640×480@60 VGA timing from `clk` at 25 MHz and streams an 8-bpp RGB332 framebuffer out of SRAM. Read data goes through a credit-limited word FIFO, and the block drives the `vga_*` pins. It acts as a second bus master alongside the CPU, behind the SRAM controller.

## Interface
Parameters:
- `ID`, default 2'd3: tag driven on `mem_id`. Returned data is accepted only when `mem_readdataid == ID`. Must be nonzero.
- `FIFO_LG`, default 6: log2 of FIFO depth in 32-bit words (64).

Ports (reset `reset_n`, synchronous, active-low; clock `clk`):
- `clk` in 1: 25 MHz pixel/bus clock.
- `reset_n` in 1: synchronous active-low reset.
- `enable` in 1: fetch/display enable, sampled only at frame restart.
- `fb_base` in 30: framebuffer word address, sampled at frame restart.
- `mem_waitrequest` in 1: responder stall.
- `mem_id` out 2: constant `ID`.
- `mem_address` out 30: word address.
- `mem_read` out 1: read request.
- `mem_readdata` in 32: returned word.
- `mem_readdataid` in 2: returned tag (0 = none).
- `vga_r`, `vga_g`, `vga_b` out 8 each: colour.
- `vga_hs`, `vga_vs` out 1: sync, active low.
- `vga_blank_n` out 1: low outside the active area.
- `underflow` out 1: sticky; cleared only by reset.

## Operation
- Counters:
  - `h` runs 0..799; `v` advances when `h` wraps and runs 0..524.
  - Active region: `h < 640` and `v < 480`.
  - HS is low for `h` 656..751; VS is low for `v` 490..491.
- Fetch:
  - `mem_read` is asserted while all of these hold: `enable_q`, `issued < 76800`, and `fifo_count + outstanding < 2^FIFO_LG`.
  - A request is accepted on any cycle with `mem_read & ~mem_waitrequest`. On acceptance, `mem_address` increments by 1, `issued` increments by 1, and `outstanding` increments by 1.
  - `mem_address` and `mem_read` hold steady while stalled.
  - `mem_write` is never driven by this block; the `mem_writedata` path is not present.
- Return:
  - On `mem_readdataid == ID`, write `mem_readdata` to the FIFO and decrement `outstanding`.
  - A simultaneous accept and return leaves `outstanding` unchanged.
- Frame restart:
  - Triggered at the first cycle of `v == 490, h == 0` with `outstanding == 0`. If `outstanding != 0`, the restart is deferred to the first cycle where it reaches 0.
  - On restart: flush the FIFO, clear `issued`, load `mem_address <= fb_base`, and capture `enable_q <= enable`.
- Pixel path:
  - In the active area, at `h[1:0] == 0`, pop one word.
  - Pixel order is big-endian: bits [31:24] first, then [23:16], [15:8], [7:0].
  - Colour expansion: `r = {p[7:5],p[7:5],p[7:6]}`, `g = {p[4:2],p[4:2],p[4:3]}`, `b = {p[1:0]×4}`.
- Underflow:
  - An empty FIFO at a required pop while `enable_q` is set sets `underflow`.
  - That 4-pixel group outputs black and no pop occurs.
- With `enable_q = 0`: no requests are issued and the active area is black. Sync timing is unaffected.

## Timing
- Reset values:
  - `h = v = 0`, `issued = 0`, `outstanding = 0`, FIFO empty.
  - `enable_q = 0`, `mem_read = 0`, `mem_address = 0`, `mem_id = ID`.
  - `vga_r/g/b = 0`, `vga_hs = vga_vs = 1`, `vga_blank_n = 0`, `underflow = 0`.
- Reset mid-burst:
  - In-flight returns tagged `ID` that arrive after reset are dropped, because `outstanding == 0`. They must not underflow the counter; saturate at 0.
  - The first valid frame starts at the first restart after reset.
- Pipeline: `vga_*` outputs are registered with a 1-cycle latency from `h`/`v`. Sync and blank are delayed equally, so colour and sync stay aligned.
- FIFO: write and pop in the same cycle are legal. A write to a full FIFO cannot occur, because of the credit rule; the bench asserts this.
- Bus throughput: the block sustains 1 request per cycle when `mem_waitrequest` is low. It needs only 160 words per 800-cycle line.

## Configuration
- `VGA_FETCH_TEST_PATTERN_EN`:
  - Defined: the fetcher is compiled out. `mem_read` is tied to 0, `underflow` is tied to 0, and the active pixel is `p = h[7:0] ^ v[7:0]`.
  - Undefined: normal framebuffer fetch as described above.

## Test plan
- Reset: hold `reset_n = 0` for 3 cycles. All outputs take their listed reset values, and `mem_read = 0` for the whole first frame until restart.
- Timing: run 2 frames. `vga_hs` has an 800-cycle period with 96 cycles low; `vga_vs` has a 420000-cycle period with 1600 cycles low; there are 307200 `vga_blank_n` high cycles per frame.
- Fetch with zero-wait responder, 2-cycle read latency, `fb_base = 30'h1000_0000`, `enable = 1`:
  - Exactly 76800 accepted reads per frame, addresses 0x1000_0000..0x1001_2BFF.
  - `outstanding` never exceeds 64.
- Pixel data: word `32'hE01C_03FF` at the first address. Pixels (0,0)..(3,0) are `FF0000`, `00FF00`, `0000FF`, `FFFFFF`.
- Stall: hold `mem_waitrequest = 1` through line 0. `underflow` rises at `h = 0, v = 0` (+1 cycle), output is black, and sync is undisturbed.
- Test-pattern build: `VGA_FETCH_TEST_PATTERN_EN` defined. `mem_read` stays 0, and pixel (5,3) has `p = 8'h06`, giving r=0, g=0x24, b=0xAA.
